// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit accumulator processor:
// opcodes, control-unit state codes, accumulator source selects and the control bundle.
package cpu_pkg;

  localparam int OPCODE_W = 3;
  localparam int STATE_W  = 4;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [3:0] ST_START   = 4'd0;
  localparam logic [3:0] ST_FETCH   = 4'd1;
  localparam logic [3:0] ST_DECODE  = 4'd2;
  localparam logic [3:0] ST_LOAD_X  = 4'd3;
  localparam logic [3:0] ST_STORE_X = 4'd4;
  localparam logic [3:0] ST_ADD_X   = 4'd5;
  localparam logic [3:0] ST_SUB_X   = 4'd6;
  localparam logic [3:0] ST_IN_WAIT = 4'd7;
  localparam logic [3:0] ST_IN_REL  = 4'd8;
  localparam logic [3:0] ST_JZ_X    = 4'd9;
  localparam logic [3:0] ST_JPOS_X  = 4'd10;
  localparam logic [3:0] ST_HALT_S  = 4'd11;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  typedef struct packed {
    logic       ir_load;
    logic       pc_load;
    logic       jmp_mux;
    logic       mem_inst;
    logic       mem_wr;
    logic       a_load;
    logic [1:0] a_sel;
    logic       sub;
    logic       halt;
  } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: opcode and status flags in, control strobes out.
interface control_unit_if #(
  parameter int OPCODE_W = 3,
  parameter int STATE_W  = 4
);
  logic [OPCODE_W-1:0] IR;
  logic                Aeq0;
  logic                Apos;
  logic                Enter;
  logic                IRload;
  logic                PCload;
  logic                JMPmux;
  logic                Meminst;
  logic                MemWr;
  logic                Aload;
  logic [1:0]          Asel;
  logic                Sub;
  logic                Halt;
  logic [STATE_W-1:0]  State;

  modport master (
    input  IR, Aeq0, Apos, Enter,
    output IRload, PCload, JMPmux, Meminst, MemWr, Aload, Asel, Sub, Halt, State
  );

  modport slave (
    output IR, Aeq0, Apos, Enter,
    input  IRload, PCload, JMPmux, Meminst, MemWr, Aload, Asel, Sub, Halt, State
  );
endinterface

// File: rtl/control_decode.sv
// Combinational output table: maps the current state plus the branch/enter
// qualifiers onto every control strobe. Only JZ/JPOS/IN_WAIT look at inputs.
module control_decode
  import cpu_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  input  logic               aeq0,
  input  logic               apos,
  input  logic               enter,
  output ctrl_t              ctrl
);

  // Output table per state; anything not set stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.ir_load = 1'b1;
        ctrl.pc_load = 1'b1;
      end
      ST_DECODE: ctrl.mem_inst = 1'b1;
      ST_LOAD_X: begin
        ctrl.mem_inst = 1'b1;
        ctrl.a_sel    = ASEL_MEM;
        ctrl.a_load   = 1'b1;
      end
      ST_STORE_X: begin
        ctrl.mem_inst = 1'b1;
        ctrl.mem_wr   = 1'b1;
      end
      ST_ADD_X: begin
        ctrl.mem_inst = 1'b1;
        ctrl.a_sel    = ASEL_ALU;
        ctrl.a_load   = 1'b1;
      end
      ST_SUB_X: begin
        ctrl.mem_inst = 1'b1;
        ctrl.a_sel    = ASEL_ALU;
        ctrl.sub      = 1'b1;
        ctrl.a_load   = 1'b1;
      end
      // A key already held when we arrive is loaded in this very cycle.
      ST_IN_WAIT: begin
        ctrl.a_sel  = ASEL_IN;
        ctrl.a_load = enter;
      end
      ST_JZ_X: begin
        ctrl.jmp_mux = 1'b1;
        ctrl.pc_load = aeq0;
      end
      ST_JPOS_X: begin
        ctrl.jmp_mux = 1'b1;
        ctrl.pc_load = apos;
      end
      ST_HALT_S: ctrl.halt = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing FSM for the accumulator processor: state register and
// next-state logic here, output strobes decoded combinationally in control_decode.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int STATE_W  = 4
) (
  input  logic           clock,
  input  logic           Reset,
  control_unit_if.master bus
);

  logic [STATE_W-1:0]  state_q;
  logic [STATE_W-1:0]  state_d;
  logic [OPCODE_W-1:0] opcode_s;
  ctrl_t               ctrl_s;

  assign opcode_s = bus.IR;

  // Next-state selection; unused encodings fall back to START.
  always_comb begin
    state_d = ST_START;
    case (state_q)
      ST_START:  state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode_s)
          OP_LOAD:  state_d = ST_LOAD_X;
          OP_STORE: state_d = ST_STORE_X;
          OP_ADD:   state_d = ST_ADD_X;
          OP_SUB:   state_d = ST_SUB_X;
          OP_IN:    state_d = ST_IN_WAIT;
          OP_JZ:    state_d = ST_JZ_X;
          OP_JPOS:  state_d = ST_JPOS_X;
          OP_HALT:  state_d = ST_HALT_S;
          default:  state_d = ST_START;
        endcase
      end
      ST_LOAD_X, ST_STORE_X, ST_ADD_X, ST_SUB_X,
      ST_JZ_X, ST_JPOS_X: state_d = ST_FETCH;
      ST_IN_WAIT: begin
        if (bus.Enter) state_d = ST_IN_REL;
        else           state_d = ST_IN_WAIT;
      end
      // Waiting for key release so one press is consumed exactly once.
      ST_IN_REL: begin
        if (bus.Enter) state_d = ST_IN_REL;
        else           state_d = ST_FETCH;
      end
      ST_HALT_S: state_d = ST_HALT_S;
      default:   state_d = ST_START;
    endcase
  end

  // State register; asynchronous reset aborts any instruction in flight.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) state_q <= ST_START;
    else        state_q <= state_d;
  end

  control_decode #(.STATE_W(STATE_W)) u_decode (
    .state (state_q),
    .aeq0  (bus.Aeq0),
    .apos  (bus.Apos),
    .enter (bus.Enter),
    .ctrl  (ctrl_s)
  );

  assign bus.IRload  = ctrl_s.ir_load;
  assign bus.PCload  = ctrl_s.pc_load;
  assign bus.JMPmux  = ctrl_s.jmp_mux;
  assign bus.Meminst = ctrl_s.mem_inst;
  assign bus.MemWr   = ctrl_s.mem_wr;
  assign bus.Aload   = ctrl_s.a_load;
  assign bus.Asel    = ctrl_s.a_sel;
  assign bus.Sub     = ctrl_s.sub;
  assign bus.Halt    = ctrl_s.halt;
  assign bus.State   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit: per-cycle vectors of inputs and expected
// state/strobes, expectations queued at drive time and popped at the sampling edge.
module tb_control_unit;

  localparam logic [3:0] S_START = 4'd0,  S_FETCH = 4'd1,  S_DEC  = 4'd2,  S_LOAD  = 4'd3;
  localparam logic [3:0] S_STORE = 4'd4,  S_ADD   = 4'd5,  S_SUB  = 4'd6,  S_INW   = 4'd7;
  localparam logic [3:0] S_INR   = 4'd8,  S_JZ    = 4'd9,  S_JPOS = 4'd10, S_HALT  = 4'd11;

  // {IRload, PCload, JMPmux, Meminst, MemWr, Aload, Asel[1:0], Sub, Halt}
  localparam logic [9:0] C_ZERO  = 10'b00_0000_0000;
  localparam logic [9:0] C_FETCH = 10'b11_0000_0000;
  localparam logic [9:0] C_DEC   = 10'b00_0100_0000;
  localparam logic [9:0] C_LOAD  = 10'b00_0101_1000;
  localparam logic [9:0] C_STORE = 10'b00_0110_0000;
  localparam logic [9:0] C_ADD   = 10'b00_0101_0000;
  localparam logic [9:0] C_SUB   = 10'b00_0101_0010;
  localparam logic [9:0] C_INW0  = 10'b00_0000_0100;
  localparam logic [9:0] C_INW1  = 10'b00_0001_0100;
  localparam logic [9:0] C_JT    = 10'b01_1000_0000;
  localparam logic [9:0] C_JN    = 10'b00_1000_0000;
  localparam logic [9:0] C_HALT  = 10'b00_0000_0001;

  typedef struct packed {
    logic       rst;
    logic [2:0] ir;
    logic       aeq0;
    logic       apos;
    logic       enter;
    logic [3:0] st;
    logic [9:0] ctl;
  } vec_t;

  logic clock;
  logic Reset;
  int   checks;
  int   errors;
  vec_t tbl[$];
  vec_t exp_q[$];

  control_unit_if #(.OPCODE_W(3), .STATE_W(4)) bus ();

  control_unit #(.OPCODE_W(3), .STATE_W(4)) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [9:0] got_ctl();
    return {bus.IRload, bus.PCload, bus.JMPmux, bus.Meminst, bus.MemWr,
            bus.Aload, bus.Asel, bus.Sub, bus.Halt};
  endfunction

  function automatic void add(input logic rst, input logic [2:0] ir, input logic a,
                              input logic p, input logic e, input logic [3:0] st,
                              input logic [9:0] ctl);
    vec_t v;
    v.rst = rst; v.ir = ir; v.aeq0 = a; v.apos = p; v.enter = e; v.st = st; v.ctl = ctl;
    tbl.push_back(v);
  endfunction

  function automatic void add_instr(input logic [2:0] ir, input logic a, input logic p,
                                    input logic [3:0] xst, input logic [9:0] xctl);
    add(1'b1, ir, a, p, 1'b0, S_FETCH, C_FETCH);
    add(1'b1, ir, a, p, 1'b0, S_DEC, C_DEC);
    add(1'b1, ir, a, p, 1'b0, xst, xctl);
  endfunction

  task automatic check_now(input string name, input logic [3:0] st, input logic [9:0] ctl);
    checks++;
    if (bus.State !== st || got_ctl() !== ctl) begin
      errors++;
      $display("FAIL %s: got state %0d ctl %b, expected state %0d ctl %b",
               name, bus.State, got_ctl(), st, ctl);
    end
  endtask

  task automatic run_tbl(input string tag);
    vec_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clock);
      #1;
      Reset     = tbl[i].rst;
      bus.IR    = tbl[i].ir;
      bus.Aeq0  = tbl[i].aeq0;
      bus.Apos  = tbl[i].apos;
      bus.Enter = tbl[i].enter;
      exp_q.push_back(tbl[i]);
      @(negedge clock);
      e = exp_q.pop_front();
      check_now($sformatf("%s row %0d", tag, i), e.st, e.ctl);
    end
    tbl.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b0; bus.IR = 3'd0; bus.Aeq0 = 1'b0; bus.Apos = 1'b0; bus.Enter = 1'b0;

    // Reset, then every instruction class including branch qualifiers and IN.
    for (int i = 0; i < 3; i++) add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, S_START, C_ZERO);
    add(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, S_START, C_ZERO);
    add_instr(3'b000, 1'b0, 1'b0, S_LOAD, C_LOAD);
    add_instr(3'b011, 1'b0, 1'b0, S_SUB, C_SUB);
    add_instr(3'b001, 1'b0, 1'b0, S_STORE, C_STORE);
    add_instr(3'b010, 1'b0, 1'b0, S_ADD, C_ADD);
    add_instr(3'b101, 1'b1, 1'b0, S_JZ, C_JT);
    add_instr(3'b101, 1'b0, 1'b1, S_JZ, C_JN);
    add_instr(3'b110, 1'b1, 1'b1, S_JPOS, C_JT);
    add_instr(3'b110, 1'b1, 1'b0, S_JPOS, C_JN);
    add(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, S_FETCH, C_FETCH);
    add(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, S_DEC, C_DEC);
    for (int i = 0; i < 5; i++) add(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, S_INW, C_INW0);
    add(1'b1, 3'b100, 1'b0, 1'b0, 1'b1, S_INW, C_INW1);
    for (int i = 0; i < 3; i++) add(1'b1, 3'b100, 1'b0, 1'b0, 1'b1, S_INR, C_ZERO);
    add(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, S_INR, C_ZERO);
    add(1'b1, 3'b100, 1'b0, 1'b0, 1'b1, S_FETCH, C_FETCH);
    add(1'b1, 3'b100, 1'b0, 1'b0, 1'b1, S_DEC, C_DEC);
    add(1'b1, 3'b100, 1'b0, 1'b0, 1'b1, S_INW, C_INW1);
    add(1'b1, 3'b100, 1'b0, 1'b0, 1'b1, S_INR, C_ZERO);
    add(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, S_INR, C_ZERO);
    add(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, S_FETCH, C_FETCH);
    add(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, S_DEC, C_DEC);
    for (int i = 0; i < 20; i++) add(1'b1, 3'b000, 1'b0, 1'b0, 1'(i % 2), S_HALT, C_HALT);
    run_tbl("main");

    // Asynchronous reset mid-cycle while halted: Halt must drop before any edge.
    #2 Reset = 1'b0;
    #1 check_now("halt_async_reset", S_START, C_ZERO);

    add(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, S_START, C_ZERO);
    add(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, S_START, C_ZERO);
    add_instr(3'b001, 1'b0, 1'b0, S_STORE, C_STORE);
    run_tbl("restart");

    // Abort a write in progress: MemWr must fall immediately.
    #2 Reset = 1'b0;
    #1 check_now("store_async_reset", S_START, C_ZERO);

    add(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, S_START, C_ZERO);
    add(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, S_START, C_ZERO);
    add_instr(3'b000, 1'b0, 1'b0, S_LOAD, C_LOAD);
    add(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, S_FETCH, C_FETCH);
    run_tbl("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
